vga_timing_ctrl: RTL
====================

Name: vga_timing_ctrl

Overview:
- Owns the VGA raster: sequences the horizontal and vertical pixel/line counters and derives hsync, vsync, video_on, pixel coordinates and frame/line strobes.
- Adds start/stop control that only starts and stops the raster on frame boundaries.
- Sits between the clock-divider pixel tick and the pixel-generation logic.
- Runs on the system clock and advances only on pix_en.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  one-clk pixel tick from clock divider
- run  in  1  level request: 1 = raster on, 0 = stop at end of frame
- running  out  1  high in ARM/RUN/DRAIN
- hcount  out  16  horizontal counter, 0..H_TOTAL-1
- vcount  out  16  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync (level per SYNC_POL)
- vsync  out  1  vertical sync (level per SYNC_POL)
- video_on  out  1  high in the visible region
- x  out  16  pixel column when video_on, else 0
- y  out  16  pixel row when video_on, else 0
- line_start  out  1  one-clk pulse when hcount loads 0
- frame_start  out  1  one-clk pulse when (hcount,vcount) loads (0,0)

Behaviour:
- Derived constants:
  - H_TOTAL = sum of H_* parameters (800 at defaults).
  - V_TOTAL = sum of V_* parameters (525 at defaults).
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - hcount, vcount, x, y = 0.
  - video_on, running, line_start, frame_start = 0.
  - hsync and vsync at their inactive level (~SYNC_POL).
- All outputs are registered. Sync, video_on, x and y are computed from the next counter values so they align with hcount/vcount in the same cycle.
- Advance event = pix_en high in RUN or DRAIN:
  - hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount at V_TOTAL-1 wraps to 0 on the same hcount wrap.
  - Counters hold whenever pix_en is low.
- hsync is active iff H_ACTIVE+H_FRONT <= hcount < H_ACTIVE+H_FRONT+H_SYNC (656..751 at defaults).
- vsync is active iff V_ACTIVE+V_FRONT <= vcount < V_ACTIVE+V_FRONT+V_SYNC (490..491 at defaults).
- video_on = (hcount < H_ACTIVE) && (vcount < V_ACTIVE).
- line_start is high for exactly the single clk after an advance that loads hcount=0. frame_start behaves the same for (0,0). Both also pulse on the ARM->RUN entry.
- FSM states:
  - IDLE: counters held at 0, syncs inactive, video_on 0. run=1 -> ARM.
  - ARM: waits for pix_en. On pix_en -> RUN with counters at (0,0) and frame_start/line_start pulsed. This pix_en does not advance the counters. run=0 while in ARM -> IDLE.
  - RUN: free-running raster. run=0 -> DRAIN on the next clk.
  - DRAIN: raster continues unchanged.
    - run=1 -> RUN; no visible discontinuity and no extra frame_start.
    - Advance at (H_TOTAL-1, V_TOTAL-1) with run=0 -> IDLE; counters go to 0, syncs inactive, no frame_start.
- Simultaneous events:
  - run falling on the same clk as the final advance of a frame, while in RUN: move to DRAIN, finish the next full frame, then IDLE. Stopping is only checked in DRAIN.
  - pix_en pulse widths greater than 1 clk advance once per clk; the upstream divider guarantees 1-clk pulses.
- Reset mid-frame: immediate IDLE with reset values. run still high after reset release -> ARM.
- Parameter sums must fit in 16 bits. Each parameter must be >= 1.

Test Plan:
- Reset then run=1, pix_en every 4 clks -> ARM to RUN on the first pix_en; frame_start one clk; hcount=0, vcount=0; hsync=vsync=1 (inactive, SYNC_POL=0).
- Free run one line -> hsync low exactly for hcount 656..751; video_on low from hcount 640; hcount 799 -> 0; vcount 0 -> 1; line_start pulse.
- Free run full frame -> vsync low only for vcount 490..491; video_on never high for vcount >= 480; vcount 524 -> 0 with frame_start; 420000 advances per frame.
- Drop run at vcount=100 -> running stays high; counters continue to (799,524); then IDLE, running=0, counters 0, no frame_start.
- Drop run at vcount=100, reassert at vcount=300 -> no discontinuity; next frame starts normally with a frame_start.
- Assert rst_n=0 at hcount=300, vcount=200 (asynchronous, between edges) -> outputs reset immediately; after release with run=1 -> ARM, then a fresh frame from (0,0).

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: pixel/line counters, syncs, visible-region decode and strobes.
// Start/stop requests take effect only on frame boundaries.
module vga_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FRONT  = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FRONT  = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        run,
    output logic        running,
    output logic [15:0] hcount,
    output logic [15:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        line_start,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS  = 16'(H_ACTIVE);
    localparam logic [15:0] V_VIS  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_LO  = 16'(H_ACTIVE + H_FRONT);
    localparam logic [15:0] HS_HI  = 16'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [15:0] VS_LO  = 16'(V_ACTIVE + V_FRONT);
    localparam logic [15:0] VS_HI  = 16'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] h_nxt;
    logic [15:0] v_nxt;
    logic [15:0] h_adv;
    logic [15:0] v_adv;
    logic        h_wrap;
    logic        v_wrap;
    logic        ls_nxt;
    logic        fs_nxt;
    logic        act_nxt;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        von_nxt;

    assign h_wrap = (hcount == H_LAST);
    assign v_wrap = (vcount == V_LAST);
    assign h_adv  = h_wrap ? 16'd0 : hcount + 16'd1;
    assign v_adv  = !h_wrap ? vcount :
                    v_wrap  ? 16'd0  : vcount + 16'd1;

    always_comb begin
        state_nxt = state;
        h_nxt     = hcount;
        v_nxt     = vcount;
        ls_nxt    = 1'b0;
        fs_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                h_nxt = 16'd0;
                v_nxt = 16'd0;
                if (run) state_nxt = ARM;
            end
            ARM: begin
                h_nxt = 16'd0;
                v_nxt = 16'd0;
                if (!run) begin
                    state_nxt = IDLE;
                end else if (pix_en) begin
                    state_nxt = RUN;
                    ls_nxt    = 1'b1;
                    fs_nxt    = 1'b1;
                end
            end
            RUN: begin
                if (pix_en) begin
                    h_nxt  = h_adv;
                    v_nxt  = v_adv;
                    ls_nxt = h_wrap;
                    fs_nxt = h_wrap && v_wrap;
                end
                if (!run) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Stop only on the advance that would begin a new frame.
                if (pix_en && h_wrap && v_wrap && !run) begin
                    state_nxt = IDLE;
                    h_nxt     = 16'd0;
                    v_nxt     = 16'd0;
                end else begin
                    if (pix_en) begin
                        h_nxt  = h_adv;
                        v_nxt  = v_adv;
                        ls_nxt = h_wrap;
                        fs_nxt = h_wrap && v_wrap;
                    end
                    if (run) state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Decode from next counter values so flags line up with registered counts.
    assign act_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);
    assign hs_nxt  = act_nxt && (h_nxt >= HS_LO) && (h_nxt < HS_HI);
    assign vs_nxt  = act_nxt && (v_nxt >= VS_LO) && (v_nxt < VS_HI);
    assign von_nxt = act_nxt && (h_nxt < H_VIS) && (v_nxt < V_VIS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            running     <= 1'b0;
            hcount      <= 16'd0;
            vcount      <= 16'd0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            x           <= 16'd0;
            y           <= 16'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            running     <= (state_nxt != IDLE);
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= hs_nxt ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_nxt ? SYNC_POL : ~SYNC_POL;
            video_on    <= von_nxt;
            x           <= von_nxt ? h_nxt : 16'd0;
            y           <= von_nxt ? v_nxt : 16'd0;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule
